// File: rtl/moment_bank_ram.sv
// Banked multi-channel moment store for the LBM lattice: sync read, pipelined accumulate, clear sweep.
// Define MOMENT_RAM_SAT_EN for saturating accumulate; otherwise accumulate wraps.
module moment_bank_ram #(
  parameter int DEPTH         = 256,
  parameter int ADDRESS_WIDTH = $clog2(DEPTH),
  parameter int DATA_WIDTH    = 64,
  parameter int NUM_CH        = 3,
  parameter int CH_WIDTH      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         Clk,
  input  logic                         Reset_n,
  input  logic                         WE,
  input  logic                         ACC,
  input  logic [ADDRESS_WIDTH-1:0]     wr_addr,
  input  logic [CH_WIDTH-1:0]          wr_ch,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  input  logic                         RE,
  input  logic [ADDRESS_WIDTH-1:0]     rd_addr,
  input  logic [CH_WIDTH-1:0]          rd_ch,
  output logic signed [DATA_WIDTH-1:0] data_out,
  output logic                         rd_valid,
  input  logic                         clear,
  output logic                         busy
);

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic [CH_WIDTH:0]        NUM_CH_W  = NUM_CH[CH_WIDTH:0];
  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH - 1);

  state_t                         state;
  logic [ADDRESS_WIDTH-1:0]       sweep_cnt;
  logic                           s2_valid;
  logic [ADDRESS_WIDTH-1:0]       s2_addr;
  logic [CH_WIDTH-1:0]            s2_ch;
  logic signed [DATA_WIDTH-1:0]   s2_data;
  logic signed [DATA_WIDTH-1:0]   mem [NUM_CH][DEPTH];

  logic                           idle_open;
  logic                           wr_ch_ok;
  logic                           rd_ch_ok;
  logic [CH_WIDTH-1:0]            wr_ch_idx;
  logic [CH_WIDTH-1:0]            rd_ch_idx;
  logic                           wr_accept;
  logic                           rd_accept;
  logic signed [DATA_WIDTH-1:0]   acc_operand;
  logic signed [DATA_WIDTH-1:0]   acc_result;
  logic signed [DATA_WIDTH-1:0]   wr_value;
  logic signed [DATA_WIDTH-1:0]   rd_value;

  // A clear request blocks every other request in the same cycle.
  assign idle_open = (state == IDLE) && !clear;
  assign wr_ch_ok  = {1'b0, wr_ch} < NUM_CH_W;
  assign rd_ch_ok  = {1'b0, rd_ch} < NUM_CH_W;
  assign wr_ch_idx = wr_ch_ok ? wr_ch : '0;
  assign rd_ch_idx = rd_ch_ok ? rd_ch : '0;
  assign wr_accept = idle_open && (WE || ACC) && wr_ch_ok;
  assign rd_accept = idle_open && RE;
  assign busy      = (state == CLEAR);

  // The op in stage 2 has not reached the array yet, so it is forwarded to both ports.
  always_comb begin
    acc_operand = mem[wr_ch_idx][wr_addr];
    if (s2_valid && s2_addr == wr_addr && s2_ch == wr_ch)
      acc_operand = s2_data;
    rd_value = mem[rd_ch_idx][rd_addr];
    if (s2_valid && s2_addr == rd_addr && s2_ch == rd_ch)
      rd_value = s2_data;
    if (!rd_ch_ok)
      rd_value = '0;
  end

`ifdef MOMENT_RAM_SAT_EN
  localparam logic signed [DATA_WIDTH-1:0] SMAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] SMIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  logic signed [DATA_WIDTH:0] sum_ext;

  assign sum_ext = {data_in[DATA_WIDTH-1], data_in} + {acc_operand[DATA_WIDTH-1], acc_operand};

  always_comb begin
    acc_result = sum_ext[DATA_WIDTH-1:0];
    if (sum_ext[DATA_WIDTH] != sum_ext[DATA_WIDTH-1])
      acc_result = sum_ext[DATA_WIDTH] ? SMIN : SMAX;
  end
`else
  assign acc_result = data_in + acc_operand;
`endif

  assign wr_value = WE ? data_in : acc_result;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      sweep_cnt <= '0;
      s2_valid  <= 1'b0;
      s2_addr   <= '0;
      s2_ch     <= '0;
      s2_data   <= '0;
      data_out  <= '0;
      rd_valid  <= 1'b0;
    end else begin
      s2_valid <= wr_accept;
      if (wr_accept) begin
        s2_addr <= wr_addr;
        s2_ch   <= wr_ch;
        s2_data <= wr_value;
      end
      rd_valid <= rd_accept;
      if (rd_accept)
        data_out <= rd_value;
      case (state)
        IDLE: begin
          if (clear) begin
            state     <= CLEAR;
            sweep_cnt <= '0;
          end
        end
        CLEAR: begin
          sweep_cnt <= sweep_cnt + 1'b1;
          if (sweep_cnt == LAST_ADDR) begin
            state     <= IDLE;
            sweep_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Storage is intentionally not reset; only the sweep zeroes it.
  always_ff @(posedge Clk) begin
    if (s2_valid)
      mem[s2_ch][s2_addr] <= s2_data;
    if (state == CLEAR)
      for (int c = 0; c < NUM_CH; c++)
        mem[c][sweep_cnt] <= '0;
  end

endmodule

// File: tb/tb_moment_bank_ram.sv
// Directed bench for moment_bank_ram: write/read, forwarding accumulate, bypass, clear sweep, reset mid-sweep.
module tb_moment_bank_ram;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        WE, ACC, RE, clear;
  logic [7:0]  wr_addr, rd_addr;
  logic [1:0]  wr_ch, rd_ch;
  logic [63:0] data_in;
  logic [63:0] data_out;
  logic        rd_valid, busy;

  int checks = 0;
  int errors = 0;

  moment_bank_ram dut (
    .Clk(Clk), .Reset_n(Reset_n), .WE(WE), .ACC(ACC),
    .wr_addr(wr_addr), .wr_ch(wr_ch), .data_in(data_in),
    .RE(RE), .rd_addr(rd_addr), .rd_ch(rd_ch),
    .data_out(data_out), .rd_valid(rd_valid),
    .clear(clear), .busy(busy)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Advance to 1ns after the next rising edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_write(input logic [1:0] ch, input logic [7:0] addr, input logic [63:0] d);
    WE = 1'b1; wr_ch = ch; wr_addr = addr; data_in = d;
    tick();
    WE = 1'b0;
  endtask

  task automatic do_acc(input logic [1:0] ch, input logic [7:0] addr, input logic [63:0] d);
    ACC = 1'b1; wr_ch = ch; wr_addr = addr; data_in = d;
    tick();
    ACC = 1'b0;
  endtask

  task automatic do_read(input logic [1:0] ch, input logic [7:0] addr,
                         output logic [63:0] d, output logic v);
    RE = 1'b1; rd_ch = ch; rd_addr = addr;
    tick();
    RE = 1'b0;
    d = data_out;
    v = rd_valid;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0; WE = 0; ACC = 0; RE = 0; clear = 0;
    wr_addr = 0; rd_addr = 0; wr_ch = 0; rd_ch = 0; data_in = 0;
    #13;
    checks++; if (data_out !== 64'd0) begin errors++; $display("[TB] FAIL reset_data_out: got %h expected 0", data_out); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd_valid: got %b expected 0", rd_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    tick();
    Reset_n = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    logic [63:0] d; logic v;
    do_write(2'd0, 8'h05, 64'h11);
    do_write(2'd2, 8'h05, 64'h22);
    do_write(2'd1, 8'h05, 64'h0100_0000_0000_0000);
    tick();
    do_read(2'd1, 8'h05, d, v);
    checks++; if (d !== 64'h0100_0000_0000_0000) begin errors++; $display("[TB] FAIL wr_rd_ch1: got %h expected 0100000000000000", d); end
    checks++; if (v !== 1'b1) begin errors++; $display("[TB] FAIL wr_rd_valid: got %b expected 1", v); end
    tick();
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL rd_valid_pulse: got %b expected 0", rd_valid); end
    checks++; if (data_out !== 64'h0100_0000_0000_0000) begin errors++; $display("[TB] FAIL data_out_hold: got %h expected 0100000000000000", data_out); end
    do_read(2'd0, 8'h05, d, v);
    checks++; if (d !== 64'h11) begin errors++; $display("[TB] FAIL wr_rd_ch0: got %h expected 11", d); end
    do_read(2'd2, 8'h05, d, v);
    checks++; if (d !== 64'h22) begin errors++; $display("[TB] FAIL wr_rd_ch2: got %h expected 22", d); end
  endtask

  task automatic test_accumulate();
    logic [63:0] d; logic v;
    do_write(2'd0, 8'h10, 64'd10);
    do_acc(2'd0, 8'h10, 64'd5);
    do_acc(2'd0, 8'h10, 64'd7);
    do_acc(2'd0, 8'h10, -64'sd2);
    tick(); tick();
    do_read(2'd0, 8'h10, d, v);
    checks++; if (d !== 64'd20) begin errors++; $display("[TB] FAIL acc_forward: got %0d expected 20", d); end
    // Accumulate from the array (no forwarding), then WE+ACC together acts as a write.
    do_acc(2'd0, 8'h10, 64'd100);
    tick(); tick();
    do_read(2'd0, 8'h10, d, v);
    checks++; if (d !== 64'd120) begin errors++; $display("[TB] FAIL acc_array: got %0d expected 120", d); end
    ACC = 1'b1;
    do_write(2'd0, 8'h10, 64'd9);
    ACC = 1'b0;
    tick(); tick();
    do_read(2'd0, 8'h10, d, v);
    checks++; if (d !== 64'd9) begin errors++; $display("[TB] FAIL we_wins: got %0d expected 9", d); end
  endtask

  task automatic test_bypass();
    WE = 1'b1; wr_ch = 2'd0; wr_addr = 8'h20; data_in = 64'd3;
    tick();
    WE = 1'b0;
    RE = 1'b1; rd_ch = 2'd0; rd_addr = 8'h20;
    tick();
    RE = 1'b0;
    checks++; if (data_out !== 64'd3) begin errors++; $display("[TB] FAIL write_first: got %0d expected 3", data_out); end
    // A read in the same cycle as the write sees the old value.
    WE = 1'b1; data_in = 64'd4; RE = 1'b1;
    tick();
    WE = 1'b0; RE = 1'b0;
    checks++; if (data_out !== 64'd3) begin errors++; $display("[TB] FAIL stage1_invisible: got %0d expected 3", data_out); end
    tick();
  endtask

  task automatic test_out_of_range();
    logic [63:0] d; logic v;
    do_write(2'd0, 8'h30, 64'h77);
    do_write(2'd3, 8'h30, 64'h55);
    tick(); tick();
    do_read(2'd3, 8'h30, d, v);
    checks++; if (d !== 64'd0 || v !== 1'b1) begin errors++; $display("[TB] FAIL oor_read: got %h/%b expected 0/1", d, v); end
    do_read(2'd0, 8'h30, d, v);
    checks++; if (d !== 64'h77) begin errors++; $display("[TB] FAIL oor_write_dropped: got %h expected 77", d); end
  endtask

  task automatic test_saturation();
    logic [63:0] d; logic v;
    logic [63:0] exp_hi, exp_lo;
`ifdef MOMENT_RAM_SAT_EN
    exp_hi = 64'h7FFF_FFFF_FFFF_FFFF;
    exp_lo = 64'h8000_0000_0000_0000;
`else
    exp_hi = 64'h8000_0000_0000_0000;
    exp_lo = 64'h7FFF_FFFF_FFFF_FFFF;
`endif
    do_write(2'd1, 8'h40, 64'h7FFF_FFFF_FFFF_FFFF);
    do_acc(2'd1, 8'h40, 64'd1);
    tick(); tick();
    do_read(2'd1, 8'h40, d, v);
    checks++; if (d !== exp_hi) begin errors++; $display("[TB] FAIL acc_overflow_pos: got %h expected %h", d, exp_hi); end
    do_write(2'd2, 8'h41, 64'h8000_0000_0000_0000);
    do_acc(2'd2, 8'h41, 64'hFFFF_FFFF_FFFF_FFFF);
    tick(); tick();
    do_read(2'd2, 8'h41, d, v);
    checks++; if (d !== exp_lo) begin errors++; $display("[TB] FAIL acc_overflow_neg: got %h expected %h", d, exp_lo); end
  endtask

  task automatic test_clear();
    logic [63:0] d; logic v;
    int count;
    logic bad_valid;
    for (int c = 0; c < 3; c++) begin
      do_write(2'(c), 8'h00, 64'hA0 + 64'(c));
      do_write(2'(c), 8'hFF, 64'hB0 + 64'(c));
      do_write(2'(c), 8'hC8, 64'hC0 + 64'(c));
    end
    clear = 1'b1; RE = 1'b1; rd_ch = 2'd0; rd_addr = 8'hFF;
    tick();
    clear = 1'b0; RE = 1'b0;
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL clear_drops_re: got %b expected 0", rd_valid); end
    count = 0; bad_valid = 1'b0;
    while (busy === 1'b1 && count < 400) begin
      count++;
      if (rd_valid !== 1'b0) bad_valid = 1'b1;
      WE = 1'b1; wr_ch = 2'd0; wr_addr = 8'h00; data_in = 64'hDEAD;
      RE = 1'b1; rd_ch = 2'd0; rd_addr = 8'h00;
      tick();
    end
    WE = 1'b0; RE = 1'b0;
    checks++; if (count !== 256) begin errors++; $display("[TB] FAIL busy_len: got %0d expected 256", count); end
    checks++; if (bad_valid !== 1'b0) begin errors++; $display("[TB] FAIL busy_rd_valid: got %b expected 0", bad_valid); end
    tick();
    for (int c = 0; c < 3; c++) begin
      do_read(2'(c), 8'h00, d, v);
      checks++; if (d !== 64'd0 || v !== 1'b1) begin errors++; $display("[TB] FAIL clear_addr00_ch%0d: got %h/%b expected 0/1", c, d, v); end
      do_read(2'(c), 8'hFF, d, v);
      checks++; if (d !== 64'd0) begin errors++; $display("[TB] FAIL clear_addrFF_ch%0d: got %h expected 0", c, d); end
    end
  endtask

  task automatic test_reset_mid_sweep();
    logic [63:0] d; logic v;
    do_write(2'd0, 8'd50, 64'h5050);
    do_write(2'd1, 8'd99, 64'h9999);
    do_write(2'd2, 8'd100, 64'h1000);
    do_write(2'd0, 8'd200, 64'h2000);
    tick(); tick();
    do_read(2'd0, 8'd200, d, v);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int k = 0; k < 100; k++) tick();
    Reset_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midsweep_busy: got %b expected 0", busy); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL midsweep_rd_valid: got %b expected 0", rd_valid); end
    checks++; if (data_out !== 64'd0) begin errors++; $display("[TB] FAIL midsweep_data_out: got %h expected 0", data_out); end
    tick();
    Reset_n = 1'b1;
    tick();
    do_read(2'd0, 8'd50, d, v);
    checks++; if (d !== 64'd0) begin errors++; $display("[TB] FAIL midsweep_addr50: got %h expected 0", d); end
    do_read(2'd1, 8'd99, d, v);
    checks++; if (d !== 64'd0) begin errors++; $display("[TB] FAIL midsweep_addr99: got %h expected 0", d); end
    do_read(2'd2, 8'd100, d, v);
    checks++; if (d !== 64'h1000) begin errors++; $display("[TB] FAIL midsweep_addr100: got %h expected 1000", d); end
    do_read(2'd0, 8'd200, d, v);
    checks++; if (d !== 64'h2000) begin errors++; $display("[TB] FAIL midsweep_addr200: got %h expected 2000", d); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_accumulate();
    test_bypass();
    test_out_of_range();
    test_saturation();
    test_clear();
    test_reset_mid_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/moment_bank_ram.md
# moment_bank_ram

Multi-channel successor to the single-port moment RAM for the LBM lattice store. Holds NUM_CH moment fields (e.g. rho, ux, uy), each DEPTH signed words, in one bank per channel. Adds a synchronous read port, a pipelined read-modify-write accumulate path with hazard forwarding, and a hardware clear sweep. Sits between the collision/streaming engines and the moment readout logic.

## Interface
- DEPTH, 256: cells per channel (16x16 lattice)
- ADDRESS_WIDTH, $clog2(DEPTH): cell address width
- DATA_WIDTH, 64: signed word width
- NUM_CH, 3: number of moment channels (>=1)
- CH_WIDTH, (NUM_CH>1 ? $clog2(NUM_CH) : 1): channel select width

Ports:
- Clk  in  1  single clock, rising edge
- Reset_n  in  1  asynchronous, active-low reset
- WE  in  1  plain write request
- ACC  in  1  accumulate request (stored word += data_in)
- wr_addr  in  ADDRESS_WIDTH  write/accumulate cell
- wr_ch  in  CH_WIDTH  write/accumulate channel
- data_in  in  DATA_WIDTH  signed write/addend data
- RE  in  1  read request
- rd_addr  in  ADDRESS_WIDTH  read cell
- rd_ch  in  CH_WIDTH  read channel
- data_out  out  DATA_WIDTH  signed read data
- rd_valid  out  1  data_out valid this cycle
- clear  in  1  start zeroing sweep (sampled, level)
- busy  out  1  sweep in progress

## Operation
- Write pipeline, one op accepted per cycle: stage 1 (accept, array read for ACC), stage 2 (commit). Every WE/ACC op accepted in cycle N commits to the array at the rising edge ending cycle N+1.
- WE and ACC both high: WE wins, treated as plain write.
- ACC operand: value of (wr_addr, wr_ch) after all earlier ops. If the stage-2 op targets the same address and channel, its result is forwarded instead of the array word (back-to-back ACC to one cell must sum correctly).
- Sum: signed data_in + operand, DATA_WIDTH result (see Configuration).
- Read: RE in cycle N -> data_out and rd_valid=1 in cycle N+1. If the stage-2 op committing in cycle N targets the same cell, the new value is returned (write-first). Stage-1 op accepted in N is not visible to a read in N.
- Out-of-range rd_ch/wr_ch (>= NUM_CH): read returns 0 with rd_valid=1; write/ACC dropped.
- FSM: IDLE, CLEAR. IDLE -> CLEAR when clear=1 sampled. CLEAR writes 0 to address k in all channels on sweep cycle k, k=0..DEPTH-1, then -> IDLE.
- clear sampled in cycle C: WE/ACC/RE in C are dropped; op accepted in C-1 still commits at end of C; sweep starts C+1.
- While busy: WE/ACC/RE ignored, rd_valid=0, clear ignored.
- Array contents are not reset; only a clear sweep zeroes them.

## Timing
- Reset (Reset_n=0, async): data_out=0, rd_valid=0, busy=0, FSM=IDLE, pipeline stages invalid, sweep counter=0.
- Reset mid-sweep: sweep aborts, partial contents remain; pending ops dropped.
- busy=1 for exactly DEPTH cycles, starting cycle C+1.
- rd_valid is a one-cycle pulse per accepted RE; data_out holds last value when rd_valid=0.
- Write/ACC commit latency 2 cycles from request to array; read latency 1.

## Configuration
- MOMENT_RAM_SAT_EN defined: ACC result saturates to signed max (2^(DATA_WIDTH-1)-1) or min (-2^(DATA_WIDTH-1)) on overflow.
- Undefined: ACC wraps modulo 2^DATA_WIDTH.

## Test plan
- Reset, WE ch1 addr 0x05 data 0x0100_0000_0000_0000, RE ch1 addr 0x05 two cycles later -> data_out=0x0100_0000_0000_0000, rd_valid=1 one cycle after RE; ch0/ch2 addr 0x05 unchanged.
- WE addr 0x10 ch0 =10, then ACC +5, +7, -2 on consecutive cycles same cell -> read returns 20 (forwarding verified).
- WE addr 0x20 =3 in cycle N, RE addr 0x20 in N+1 -> data_out=3 in N+2 (write-first bypass).
- Write nonzero to addr 0x00 and 0xFF in all channels, pulse clear -> busy high 256 cycles, RE/WE ignored meanwhile, afterwards all reads return 0.
- WE 0x7FFF_FFFF_FFFF_FFFF then ACC +1 -> 0x7FFF_FFFF_FFFF_FFFF with MOMENT_RAM_SAT_EN, 0x8000_0000_0000_0000 without.
- Assert Reset_n low at sweep cycle 100 -> busy=0, rd_valid=0 immediately; addr 0..99 read 0, addr 200 retains prior data.
